// File: rtl/ddr_axi_pkg.sv
// Shared constants, FSM state encoding and address helpers for the on-chip DDR stand-in responder.
package ddr_axi_pkg;

  localparam int unsigned MemDqWidthDef    = 32;
  localparam int unsigned CtrlAddrWidthDef = 28;
  // One address unit is MEM_DQ_WIDTH bits, so a 256-bit beat spans 8 units.
  localparam int unsigned UnitsPerBeatLog2 = 3;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWrData = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;
  localparam logic [1:0] StRdData = 2'd3;

  function automatic logic [31:0] beat_index(input logic [31:0] addr);
    return addr >> UnitsPerBeatLog2;
  endfunction

endpackage

// File: rtl/ddr_axi_responder_if.sv
// User-side AXI port of the DDR controller as seen by the frame-buffer initiator.
interface ddr_axi_responder_if
  import ddr_axi_pkg::*;
#(
  parameter int unsigned MEM_DQ_WIDTH    = MemDqWidthDef,
  parameter int unsigned CTRL_ADDR_WIDTH = CtrlAddrWidthDef
);
  logic [CTRL_ADDR_WIDTH-1:0] axi_awaddr;
  logic [3:0]                 axi_awuser_id;
  logic [3:0]                 axi_awlen;
  logic                       axi_awvalid;
  logic                       axi_awready;
  logic [MEM_DQ_WIDTH*8-1:0]  axi_wdata;
  logic [MEM_DQ_WIDTH-1:0]    axi_wstrb;
  logic                       axi_wready;
  logic                       axi_wusero_last;
  logic [CTRL_ADDR_WIDTH-1:0] axi_araddr;
  logic [3:0]                 axi_aruser_id;
  logic [3:0]                 axi_arlen;
  logic                       axi_arvalid;
  logic                       axi_arready;
  logic [MEM_DQ_WIDTH*8-1:0]  axi_rdata;
  logic [3:0]                 axi_rid;
  logic                       axi_rlast;
  logic                       axi_rvalid;

  modport master (
    output axi_awaddr, axi_awuser_id, axi_awlen, axi_awvalid,
    output axi_wdata, axi_wstrb,
    output axi_araddr, axi_aruser_id, axi_arlen, axi_arvalid,
    input  axi_awready, axi_wready, axi_wusero_last,
    input  axi_arready, axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_awaddr, axi_awuser_id, axi_awlen, axi_awvalid,
    input  axi_wdata, axi_wstrb,
    input  axi_araddr, axi_aruser_id, axi_arlen, axi_arvalid,
    output axi_awready, axi_wready, axi_wusero_last,
    output axi_arready, axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/ddr_resp_ram.sv
// Simple dual-port beat RAM: one byte-enabled write port, one read port with registered output.
module ddr_resp_ram #(
  parameter int unsigned Width     = 256,
  parameter int unsigned DepthLog2 = 10
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [DepthLog2-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic [Width/8-1:0]   wbe_i,
  input  logic [DepthLog2-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem [2**DepthLog2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < Width / 8; b++) begin
        if (wbe_i[b]) mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/ddr_axi_responder.sv
// RAM-backed stand-in for the DDR controller user AXI port, one burst in flight at a time.
// Define AXI_RESP_STALL_EN to insert a one-cycle bubble after every 4th beat of a burst.
module ddr_axi_responder
  import ddr_axi_pkg::*;
#(
  parameter int unsigned MEM_DQ_WIDTH    = MemDqWidthDef,
  parameter int unsigned CTRL_ADDR_WIDTH = CtrlAddrWidthDef,
  parameter int unsigned DEPTH_LOG2      = 10,
  parameter int unsigned RD_LAT          = 4
) (
  input logic                core_clk,
  input logic                rst,
  ddr_axi_responder_if.slave axi
);

  localparam int unsigned BeatW = MEM_DQ_WIDTH * 8;

`ifdef AXI_RESP_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic [1:0]            state_q, state_d;
  logic                  prio_wr_q, prio_wr_d;
  logic                  awready_q, awready_d;
  logic                  arready_q, arready_d;
  logic                  wready_q, wready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  stall_q, stall_d;
  logic [4:0]            beat_q, beat_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            id_q, id_d;
  logic [3:0]            lat_q, lat_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;

  logic [CTRL_ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [BeatW-1:0]           ram_rdata;
  logic                       ram_we;
  logic                       rd_issue;
  logic                       last_beat;
  logic                       stall_point;
  logic                       unused_id;

  assign aw_addr     = axi.axi_awaddr;
  assign ar_addr     = axi.axi_araddr;
  assign unused_id   = ^axi.axi_awuser_id;
  assign last_beat   = (beat_q == {1'b0, len_q});
  assign stall_point = StallEn && (beat_q[1:0] == 2'b11);

  always_comb begin
    state_d   = state_q;
    prio_wr_d = prio_wr_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    wready_d  = 1'b0;
    rvalid_d  = 1'b0;
    rlast_d   = 1'b0;
    stall_d   = stall_q;
    beat_d    = beat_q;
    len_d     = len_q;
    id_d      = id_q;
    lat_d     = lat_q;
    idx_d     = idx_q;
    ram_we    = 1'b0;
    rd_issue  = 1'b0;

    case (state_q)
      StIdle: begin
        stall_d = 1'b0;
        // Alternate between channels when both request in the same cycle.
        if (axi.axi_awvalid && (prio_wr_q || !axi.axi_arvalid)) begin
          awready_d = 1'b1;
          prio_wr_d = 1'b0;
          state_d   = StWrData;
        end else if (axi.axi_arvalid) begin
          arready_d = 1'b1;
          prio_wr_d = 1'b1;
          state_d   = StRdWait;
        end
      end

      StWrData: begin
        if (awready_q) begin
          idx_d    = DEPTH_LOG2'(beat_index(32'(aw_addr)));
          len_d    = axi.axi_awlen;
          beat_d   = '0;
          wready_d = 1'b1;
        end else if (wready_q) begin
          ram_we = 1'b1;
          idx_d  = idx_q + 1'b1;
          beat_d = beat_q + 5'd1;
          if (last_beat) begin
            state_d = StIdle;
          end else begin
            wready_d = !stall_point;
          end
        end else begin
          wready_d = 1'b1;
        end
      end

      StRdWait: begin
        if (arready_q) begin
          idx_d   = DEPTH_LOG2'(beat_index(32'(ar_addr)));
          len_d   = axi.axi_arlen;
          id_d    = axi.axi_aruser_id;
          beat_d  = '0;
          stall_d = 1'b0;
          lat_d   = 4'd1;
        end else if (lat_q == 4'(RD_LAT - 1)) begin
          // RAM output is registered, so issuing here lands rvalid RD_LAT cycles after arready.
          rd_issue = 1'b1;
          state_d  = StRdData;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      default: begin
        if (rlast_q) begin
          state_d = StIdle;
        end else if (stall_q) begin
          stall_d = 1'b0;
        end else if (beat_q <= {1'b0, len_q}) begin
          rd_issue = 1'b1;
        end
      end
    endcase

    if (rd_issue) begin
      rvalid_d = 1'b1;
      rlast_d  = last_beat;
      idx_d    = idx_q + 1'b1;
      beat_d   = beat_q + 5'd1;
      stall_d  = stall_point && !last_beat;
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      prio_wr_q <= 1'b1;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      stall_q   <= 1'b0;
      beat_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      lat_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_wr_q <= prio_wr_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      stall_q   <= stall_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      id_q      <= id_d;
      lat_q     <= lat_d;
      idx_q     <= idx_d;
    end
  end

  // A beat presented in the reset cycle is dropped with the rest of the burst.
  ddr_resp_ram #(
    .Width     (BeatW),
    .DepthLog2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (core_clk),
    .we_i    (ram_we && !rst),
    .waddr_i (idx_q),
    .wdata_i (axi.axi_wdata),
    .wbe_i   (axi.axi_wstrb),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata)
  );

  assign axi.axi_awready     = awready_q;
  assign axi.axi_arready     = arready_q;
  assign axi.axi_wready      = wready_q;
  assign axi.axi_wusero_last = wready_q && last_beat;
  assign axi.axi_rvalid      = rvalid_q;
  assign axi.axi_rlast       = rlast_q;
  assign axi.axi_rdata       = rvalid_q ? ram_rdata : '0;
  assign axi.axi_rid         = rvalid_q ? id_q : 4'd0;

endmodule

// File: tb/tb_ddr_axi_responder.sv
// Randomised self-checking bench for ddr_axi_responder against a beat-array reference model.
module tb_ddr_axi_responder;

  localparam int unsigned RdLat = 4;
  localparam int unsigned Depth = 1024;

`ifdef AXI_RESP_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic core_clk = 1'b0;
  logic rst = 1'b1;
  always #5 core_clk = ~core_clk;

  ddr_axi_responder_if #(.MEM_DQ_WIDTH(32), .CTRL_ADDR_WIDTH(28)) axi ();

  ddr_axi_responder #(
    .MEM_DQ_WIDTH    (32),
    .CTRL_ADDR_WIDTH (28),
    .DEPTH_LOG2      (10),
    .RD_LAT          (RdLat)
  ) dut (
    .core_clk (core_clk),
    .rst      (rst),
    .axi      (axi)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: beat storage plus a per-byte "has been written" map.
  logic [255:0] mem_m [Depth];
  logic [31:0]  bval  [Depth];
  logic [255:0] wbuf  [16];
  logic [31:0]  sbuf  [16];
  bit           last_wr = 1'b0;  // 0: write wins the next simultaneous request

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int beat_of(input logic [27:0] addr, input int i);
    return ((int'(addr) >> 3) + i) % Depth;
  endfunction

  task automatic write_burst(input logic [27:0] addr, input logic [3:0] len, input int rst_beat);
    bit seen = 1'b0;
    int idx;
    axi.axi_awaddr    = addr;
    axi.axi_awlen     = len;
    axi.axi_awuser_id = 4'($urandom);
    axi.axi_awvalid   = 1'b1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge core_clk);
      check_eq("no_arready_in_aw", 256'(axi.axi_arready), 256'(0));
      seen = axi.axi_awready;
    end
    check_eq("aw_handshake", 256'(seen), 256'(1));
    if (!seen) begin
      axi.axi_awvalid = 1'b0;
      return;
    end
    last_wr = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      if (StallEn && i > 0 && i % 4 == 0) begin
        @(negedge core_clk);
        check_eq("w_stall_gap", 256'(axi.axi_wready), 256'(0));
      end
      @(negedge core_clk);
      axi.axi_awvalid = 1'b0;
      if (i == 0) check_eq("awready_pulse", 256'(axi.axi_awready), 256'(0));
      check_eq("wready", 256'(axi.axi_wready), 256'(1));
      check_eq("wlast", 256'(axi.axi_wusero_last), 256'(i == int'(len)));
      axi.axi_wdata = wbuf[i];
      axi.axi_wstrb = sbuf[i];
      if (i == rst_beat) begin
        rst = 1'b1;
        @(negedge core_clk);
        rst = 1'b0;
        check_eq("wready_after_rst", 256'(axi.axi_wready), 256'(0));
        check_eq("wlast_after_rst", 256'(axi.axi_wusero_last), 256'(0));
        last_wr = 1'b0;
        return;
      end
      idx = beat_of(addr, i);
      for (int b = 0; b < 32; b++) begin
        if (sbuf[i][b]) begin
          mem_m[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
          bval[idx][b] = 1'b1;
        end
      end
    end
    @(negedge core_clk);
    check_eq("wready_end", 256'(axi.axi_wready), 256'(0));
  endtask

  task automatic read_burst(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id);
    bit seen = 1'b0;
    bit pat[$];
    int beat = 0;
    int idx;
    logic [255:0] mask;
    axi.axi_araddr    = addr;
    axi.axi_arlen     = len;
    axi.axi_aruser_id = id;
    axi.axi_arvalid   = 1'b1;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge core_clk);
      check_eq("no_awready_in_ar", 256'(axi.axi_awready), 256'(0));
      seen = axi.axi_arready;
    end
    check_eq("ar_handshake", 256'(seen), 256'(1));
    axi.axi_arvalid = 1'b0;
    if (!seen) return;
    last_wr = 1'b0;
    for (int i = 0; i < int'(RdLat) - 1; i++) pat.push_back(1'b0);
    for (int i = 0; i <= int'(len); i++) begin
      if (StallEn && i > 0 && i % 4 == 0) pat.push_back(1'b0);
      pat.push_back(1'b1);
    end
    foreach (pat[c]) begin
      @(negedge core_clk);
      if (c == 0) check_eq("arready_pulse", 256'(axi.axi_arready), 256'(0));
      check_eq("rvalid", 256'(axi.axi_rvalid), 256'(pat[c]));
      if (pat[c]) begin
        idx = beat_of(addr, beat);
        for (int b = 0; b < 32; b++) mask[b*8 +: 8] = bval[idx][b] ? 8'hFF : 8'h00;
        check_eq("rdata", axi.axi_rdata & mask, mem_m[idx] & mask);
        check_eq("rid", 256'(axi.axi_rid), 256'(id));
        check_eq("rlast", 256'(axi.axi_rlast), 256'(beat == int'(len)));
        beat++;
      end else begin
        check_eq("rdata_idle", axi.axi_rdata, 256'(0));
      end
    end
    @(negedge core_clk);
    check_eq("rvalid_end", 256'(axi.axi_rvalid), 256'(0));
    check_eq("rlast_end", 256'(axi.axi_rlast), 256'(0));
  endtask

  task automatic fill_random(input bit full_strb);
    for (int i = 0; i < 16; i++) begin
      for (int w = 0; w < 8; w++) wbuf[i][w*32 +: 32] = $urandom;
      sbuf[i] = (full_strb || $urandom_range(0, 2) != 0) ? 32'hFFFF_FFFF : $urandom;
    end
  endtask

  initial begin
    logic [31:0] word;
    logic [27:0] a;
    logic [3:0]  l;
    logic [3:0]  id;

    for (int i = 0; i < int'(Depth); i++) begin
      mem_m[i] = '0;
      bval[i]  = '0;
    end
    axi.axi_awaddr = '0; axi.axi_awuser_id = '0; axi.axi_awlen = '0; axi.axi_awvalid = 1'b0;
    axi.axi_wdata = '0; axi.axi_wstrb = '0;
    axi.axi_araddr = '0; axi.axi_aruser_id = '0; axi.axi_arlen = '0; axi.axi_arvalid = 1'b0;

    repeat (3) @(negedge core_clk);
    rst = 1'b0;
    @(negedge core_clk);
    check_eq("rst_awready", 256'(axi.axi_awready), 256'(0));
    check_eq("rst_arready", 256'(axi.axi_arready), 256'(0));
    check_eq("rst_wready", 256'(axi.axi_wready), 256'(0));
    check_eq("rst_wlast", 256'(axi.axi_wusero_last), 256'(0));
    check_eq("rst_rvalid", 256'(axi.axi_rvalid), 256'(0));
    check_eq("rst_rlast", 256'(axi.axi_rlast), 256'(0));
    check_eq("rst_rdata", axi.axi_rdata, 256'(0));
    check_eq("rst_rid", 256'(axi.axi_rid), 256'(0));

    // 16-beat write then read-back of a k*0x01010101 pattern
    for (int k = 0; k < 16; k++) begin
      word    = 32'(k) * 32'h0101_0101;
      wbuf[k] = {8{word}};
      sbuf[k] = 32'hFFFF_FFFF;
    end
    write_burst(28'h0, 4'd15, -1);
    read_burst(28'h0, 4'd15, 4'h5);

    // Byte strobes: only the low four bytes are overwritten
    wbuf[0] = '1;
    sbuf[0] = 32'hFFFF_FFFF;
    write_burst(28'h40, 4'd0, -1);
    wbuf[0] = '0;
    sbuf[0] = 32'h0000_000F;
    write_burst(28'h40, 4'd0, -1);
    read_burst(28'h40, 4'd0, 4'h2);

    // Simultaneous requests alternate: write, read, write
    fill_random(1'b1);
    axi.axi_awaddr = 28'h200; axi.axi_awlen = 4'd2; axi.axi_awvalid = 1'b1;
    axi.axi_araddr = 28'h200; axi.axi_arlen = 4'd2; axi.axi_aruser_id = 4'h9;
    axi.axi_arvalid = 1'b1;
    write_burst(28'h200, 4'd2, -1);
    axi.axi_awaddr = 28'h300; axi.axi_awlen = 4'd1; axi.axi_awvalid = 1'b1;
    read_burst(28'h200, 4'd2, 4'h9);
    write_burst(28'h300, 4'd1, -1);
    read_burst(28'h300, 4'd1, 4'h3);

    // Wrap of the beat index past the top of the RAM
    fill_random(1'b1);
    write_burst(28'h1FF0, 4'd3, -1);
    read_burst(28'h0, 4'd0, 4'h1);
    read_burst(28'h1FF0, 4'd3, 4'h7);

    // Reset in the middle of a 16-beat write
    fill_random(1'b1);
    write_burst(28'h800, 4'd15, 5);
    fill_random(1'b1);
    write_burst(28'h1000, 4'd0, -1);
    read_burst(28'h800, 4'd4, 4'hA);

    // Random bursts, some with both channels requesting together
    for (int it = 0; it < 12; it++) begin
      fill_random(1'b0);
      a  = 28'($urandom);
      l  = 4'($urandom);
      id = 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        write_burst(a, l, -1);
        read_burst(a, l, id);
      end else begin
        axi.axi_awaddr = a; axi.axi_awlen = l; axi.axi_awvalid = 1'b1;
        axi.axi_araddr = a; axi.axi_arlen = l; axi.axi_aruser_id = id;
        axi.axi_arvalid = 1'b1;
        if (last_wr) begin
          read_burst(a, l, id);
          write_burst(a, l, -1);
        end else begin
          write_burst(a, l, -1);
          read_burst(a, l, id);
        end
        read_burst(a, l, id);
      end
      repeat ($urandom_range(0, 2)) @(negedge core_clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
